// File: rtl/wb_rackctl_arbiter.sv
// Two-master WISHBONE arbiter (M0 = RACKctl, M1 = command processor) with round-robin grant held per cycle.
// Optional slave watchdog enabled by defining WB_RACKCTL_ARB_TIMEOUT_EN.
module wb_rackctl_arbiter #(
    parameter int ADDR_BITS      = 22,
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic [ADDR_BITS-1:0]   m0_adr_i,
    input  logic [DATA_BITS-1:0]   m0_dat_i,
    input  logic [DATA_BITS/8-1:0] m0_sel_i,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,
    output logic                   m0_rty_o,
    output logic [DATA_BITS-1:0]   m0_dat_o,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic [ADDR_BITS-1:0]   m1_adr_i,
    input  logic [DATA_BITS-1:0]   m1_dat_i,
    input  logic [DATA_BITS/8-1:0] m1_sel_i,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,
    output logic                   m1_rty_o,
    output logic [DATA_BITS-1:0]   m1_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [ADDR_BITS-1:0]   s_adr_o,
    output logic [DATA_BITS-1:0]   s_dat_o,
    output logic [DATA_BITS/8-1:0] s_sel_o,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic                   s_rty_i,
    input  logic [DATA_BITS-1:0]   s_dat_i,
    output logic [1:0]             grant_o,
    output logic [7:0]             timeout_cnt_o
);

    localparam int SEL_BITS = DATA_BITS / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
`ifdef WB_RACKCTL_ARB_TIMEOUT_EN
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT_CYCLES - 1);
`endif

    logic [1:0]           r_state;
    logic [1:0]           r_grant;
    logic                 r_last_m1;
    logic [1:0]           w_state_nxt;
    logic [1:0]           w_grant_nxt;
    logic                 w_last_m1_nxt;

    logic                 w_own_cyc;
    logic                 w_own_stb;
    logic                 w_own_we;
    logic [ADDR_BITS-1:0] w_own_adr;
    logic [DATA_BITS-1:0] w_own_dat;
    logic [SEL_BITS-1:0]  w_own_sel;

    logic                 w_busy;
    logic                 w_timeout;
    logic                 w_pass;
    logic                 w_rsp_en;

    // Select the request lines of whichever master currently owns the bus.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_dat = '0;
        w_own_sel = '0;
        if (r_grant[0]) begin
            w_own_cyc = m0_cyc_i;
            w_own_stb = m0_stb_i;
            w_own_we  = m0_we_i;
            w_own_adr = m0_adr_i;
            w_own_dat = m0_dat_i;
            w_own_sel = m0_sel_i;
        end else if (r_grant[1]) begin
            w_own_cyc = m1_cyc_i;
            w_own_stb = m1_stb_i;
            w_own_we  = m1_we_i;
            w_own_adr = m1_adr_i;
            w_own_dat = m1_dat_i;
            w_own_sel = m1_sel_i;
        end else begin
            w_own_cyc = 1'b0;
        end
    end

    assign w_busy = (r_state == ST_BUSY);

`ifdef WB_RACKCTL_ARB_TIMEOUT_EN
    logic       w_resp;
    logic [9:0] r_wd_cnt;
    logic [7:0] r_to_cnt;

    assign w_resp = s_ack_i | s_err_i | s_rty_i;
    // A response arriving on the limit cycle wins over the abort.
    assign w_timeout = w_busy & w_own_cyc & w_own_stb & ~w_resp & (r_wd_cnt == WD_LIMIT);

    // Watchdog: counts strobed cycles without a slave response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wd_cnt <= 10'd0;
        end else if (!w_busy || w_resp || w_timeout) begin
            r_wd_cnt <= 10'd0;
        end else if (w_own_cyc && w_own_stb) begin
            r_wd_cnt <= r_wd_cnt + 10'd1;
        end else begin
            r_wd_cnt <= r_wd_cnt;
        end
    end

    // Saturating count of watchdog aborts.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_to_cnt <= 8'd0;
        end else if (w_timeout && (r_to_cnt != 8'hFF)) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end

    assign timeout_cnt_o = r_to_cnt;
`else
    assign w_timeout     = 1'b0;
    assign timeout_cnt_o = 8'd0;
`endif

    // Slave side follows the owner only while it holds cyc; drops with cyc in the same cycle.
    assign w_pass   = w_busy & w_own_cyc & ~w_timeout;
    assign w_rsp_en = w_pass & w_own_stb;

    assign s_cyc_o  = w_pass;
    assign s_stb_o  = w_pass & w_own_stb;
    assign s_we_o   = w_pass & w_own_we;
    assign s_adr_o  = w_pass ? w_own_adr : {ADDR_BITS{1'b0}};
    assign s_dat_o  = w_pass ? w_own_dat : {DATA_BITS{1'b0}};
    assign s_sel_o  = w_pass ? w_own_sel : {SEL_BITS{1'b0}};

    assign m0_ack_o = w_rsp_en & r_grant[0] & s_ack_i;
    assign m0_err_o = (w_rsp_en & r_grant[0] & s_err_i) | (w_timeout & r_grant[0]);
    assign m0_rty_o = w_rsp_en & r_grant[0] & s_rty_i;
    assign m0_dat_o = (w_pass & r_grant[0]) ? s_dat_i : {DATA_BITS{1'b0}};

    assign m1_ack_o = w_rsp_en & r_grant[1] & s_ack_i;
    assign m1_err_o = (w_rsp_en & r_grant[1] & s_err_i) | (w_timeout & r_grant[1]);
    assign m1_rty_o = w_rsp_en & r_grant[1] & s_rty_i;
    assign m1_dat_o = (w_pass & r_grant[1]) ? s_dat_i : {DATA_BITS{1'b0}};

    assign grant_o  = r_grant;

    // Arbitration state machine: round-robin pick in IDLE, hold while owner keeps cyc.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_m1_nxt = r_last_m1;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = r_last_m1 ? 2'b01 : 2'b10;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = 2'b01;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = 2'b10;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!w_own_cyc) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = 2'b00;
                    w_last_m1_nxt = r_grant[1];
`ifdef WB_RACKCTL_ARB_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_state_nxt = ST_ABORT;
`endif
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
`ifdef WB_RACKCTL_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!w_own_cyc) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = 2'b00;
                    w_last_m1_nxt = r_grant[1];
                end else begin
                    w_state_nxt = ST_ABORT;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // State, owner and round-robin history registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= 2'b00;
            r_last_m1 <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last_m1 <= w_last_m1_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rackctl_arbiter.sv
// Directed self-checking bench for wb_rackctl_arbiter; watchdog cases are built when WB_RACKCTL_ARB_TIMEOUT_EN is defined.
module tb_wb_rackctl_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [21:0] m0_adr_i;
    logic [31:0] m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [21:0] m1_adr_i;
    logic [31:0] m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [21:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic [7:0]  timeout_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_rackctl_arbiter #(
        .ADDR_BITS(22), .DATA_BITS(32), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge wb_clk_i);
    endtask

    task automatic do_reset();
        wb_rst_n_i = 1'b0;
        nxt();
        nxt();
        wb_rst_n_i = 1'b1;
    endtask

`ifdef WB_RACKCTL_ARB_TIMEOUT_EN
    // One M0 cycle with a silent slave, or a slave that acks exactly on the 16th strobed cycle.
    task automatic to_round(input bit ack16, input bit do_chk);
        m0_cyc_i = 1'b1;
        m0_stb_i = 1'b1;
        nxt();
        for (int k = 1; k <= 16; k++) begin
            if (k == 16 && ack16) s_ack_i = 1'b1;
            smp();
            if (do_chk && k == 15) begin
                chk("wd_c15_err", 32'(m0_err_o), 32'd0);
                chk("wd_c15_cyc", 32'(s_cyc_o), 32'd1);
            end
            if (do_chk && k == 16) begin
                chk("wd_c16_err", 32'(m0_err_o), ack16 ? 32'd0 : 32'd1);
                chk("wd_c16_ack", 32'(m0_ack_o), ack16 ? 32'd1 : 32'd0);
                chk("wd_c16_cyc", 32'(s_cyc_o),  ack16 ? 32'd1 : 32'd0);
            end
            nxt();
        end
        s_ack_i = 1'b0;
        smp();
        if (do_chk && !ack16) begin
            chk("wd_abort_err", 32'(m0_err_o), 32'd0);
            chk("wd_abort_cyc", 32'(s_cyc_o), 32'd0);
        end
        m0_cyc_i = 1'b0;
        m0_stb_i = 1'b0;
        nxt();
        nxt();
    endtask
`endif

    initial begin
        wb_rst_n_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m0_adr_i = 22'd0; m0_dat_i = 32'd0; m0_sel_i = 4'd0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_adr_i = 22'd0; m1_dat_i = 32'd0; m1_sel_i = 4'd0;
        s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1; s_dat_i = 32'hFFFF_FFFF;

        // Reset: every output quiet even with slave lines driven.
        smp();
        chk("rst_outputs", 32'(|{m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
                                 m1_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
                                 grant_o, timeout_cnt_o}), 32'd0);
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = 32'd0;
        do_reset();

        // Test 1: M0 write, ack on the second granted cycle.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_adr_i = 22'h000010; m0_dat_i = 32'hDEADBEEF; m0_sel_i = 4'hF;
        smp();
        chk("t1_arb_latency", 32'(s_cyc_o), 32'd0);
        nxt();
        smp();
        chk("t1_grant", 32'(grant_o), 32'd1);
        chk("t1_scyc", 32'(s_cyc_o), 32'd1);
        chk("t1_adr", 32'(s_adr_o), 32'h10);
        chk("t1_dat", s_dat_o, 32'hDEADBEEF);
        chk("t1_we_sel", 32'({s_we_o, s_sel_o}), 32'h1F);
        chk("t1_no_early_ack", 32'(m0_ack_o), 32'd0);
        nxt();
        s_ack_i = 1'b1;
        smp();
        chk("t1_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("t1_m1_ack", 32'(m1_ack_o), 32'd0);
        nxt();
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        smp();
        chk("t1_cyc_drop", 32'(s_cyc_o), 32'd0);
        chk("t1_single_ack", 32'(m0_ack_o), 32'd0);
        nxt();
        smp();
        chk("t1_idle_grant", 32'(grant_o), 32'd0);

        // Test 2: both masters request together, four rounds.
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        nxt();
        for (int r = 0; r < 4; r++) begin
            s_ack_i = 1'b1;
            smp();
            chk("t2_grant", 32'(grant_o), (r % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_scyc", 32'(s_cyc_o), 32'd1);
            chk("t2_acks", 32'({m1_ack_o, m0_ack_o}), (r % 2 == 0) ? 32'd1 : 32'd2);
            nxt();
            s_ack_i = 1'b0;
            if (r % 2 == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            else            begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            smp();
            chk("t2_drop_cyc", 32'(s_cyc_o), 32'd0);
            nxt();
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
            m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            smp();
            chk("t2_dead_cycle", 32'({grant_o, s_cyc_o}), 32'd0);
            nxt();
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        nxt();
        nxt();

        // Test 3: M1 read at top address, slave errors with data.
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 22'h3FFFFF; m1_sel_i = 4'hF;
        nxt();
        s_err_i = 1'b1; s_dat_i = 32'h12345678;
        smp();
        chk("t3_grant", 32'(grant_o), 32'd2);
        chk("t3_adr", 32'(s_adr_o), 32'h3FFFFF);
        chk("t3_m1_err", 32'(m1_err_o), 32'd1);
        chk("t3_m1_dat", m1_dat_o, 32'h12345678);
        chk("t3_m0_quiet", 32'(|{m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o}), 32'd0);
        nxt();
        s_err_i = 1'b0; s_ack_i = 1'b1; m1_stb_i = 1'b0;
        smp();
        chk("t3_ack_no_stb", 32'(m1_ack_o), 32'd0);
        nxt();
        s_ack_i = 1'b0; s_dat_i = 32'd0;
        m1_cyc_i = 1'b0;
        nxt();
        nxt();

        // Test 4: asynchronous reset while M0 owns the bus; M1 waiting.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        nxt();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1;
        #1;
        chk("t4_pre_ack", 32'(m0_ack_o), 32'd1);
        wb_rst_n_i = 1'b0;
        #1;
        chk("t4_async_clear", 32'(|{grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}), 32'd0);
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        nxt();
        wb_rst_n_i = 1'b1;
        nxt();
        smp();
        chk("t4_m1_first", 32'(grant_o), 32'd2);
        chk("t4_wd_count", 32'(timeout_cnt_o), 32'd0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        nxt();
        nxt();

`ifdef WB_RACKCTL_ARB_TIMEOUT_EN
        // Tests 5/6: watchdog abort, ack exactly on the limit cycle, then saturation.
        do_reset();
        to_round(1'b0, 1'b1);
        chk("t5_count_1", 32'(timeout_cnt_o), 32'd1);
        to_round(1'b1, 1'b1);
        chk("t6_count_kept", 32'(timeout_cnt_o), 32'd1);
        for (int i = 0; i < 254; i++) to_round(1'b0, 1'b0);
        chk("t5_count_255", 32'(timeout_cnt_o), 32'd255);
        to_round(1'b0, 1'b1);
        chk("t5_saturate", 32'(timeout_cnt_o), 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
